// File: rtl/alu_issue_unit.sv
// Sequential issue front end for the combinational alu: registers one request, holds the alu
// inputs for a fixed settle time, captures result/flags and returns them on a response channel.
module alu_issue_unit #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SEL_W         = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [SEL_W-1:0] i_req_select,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  output logic [SEL_W-1:0] o_alu_select,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_alu_z,
  input  logic             i_alu_n,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_z,
  output logic             o_rsp_n,
  output logic             o_flag_z,
  output logic             o_flag_n,
  output logic             o_busy,
  output logic [15:0]      o_op_count
);

  typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [3:0]         r_cnt;
  logic [SEL_W-1:0]   r_alu_select;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_z;
  logic               r_rsp_n;
  logic               r_flag_z;
  logic               r_flag_n;
  logic [15:0]        r_op_count;
  logic               w_accept;
  logic               w_capture;

  assign w_accept  = i_req_valid && (r_state == StIdle);
  assign w_capture = (r_state == StDrive) && (r_cnt == 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_req_valid) w_state_next = StDrive;
      StDrive: if (r_cnt == 4'd0) w_state_next = StHold;
      StHold:  if (i_rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake outputs decode state only, so there is no combinational input-to-output path.
  always_comb begin
    o_req_ready = (r_state == StIdle);
    o_rsp_valid = (r_state == StHold);
    o_busy      = (r_state != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= 4'd0;
      r_alu_select <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_result <= '0;
      r_rsp_z      <= 1'b0;
      r_rsp_n      <= 1'b0;
      r_flag_z     <= 1'b0;
      r_flag_n     <= 1'b0;
      r_op_count   <= 16'd0;
    end else begin
      if (w_accept) begin
        r_alu_select <= i_req_select;
        r_alu_a      <= i_req_a;
        r_alu_b      <= i_req_b;
        r_cnt        <= CntInit;
      end else if ((r_state == StDrive) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_rsp_result <= i_alu_out;
        r_rsp_z      <= i_alu_z;
        r_rsp_n      <= i_alu_n;
        r_flag_z     <= i_alu_z;
        r_flag_n     <= i_alu_n;
        r_op_count   <= r_op_count + 16'd1;
      end
    end
  end

  assign o_alu_select = r_alu_select;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_z      = r_rsp_z;
  assign o_rsp_n      = r_rsp_n;
  assign o_flag_z     = r_flag_z;
  assign o_flag_n     = r_flag_n;
  assign o_op_count   = r_op_count;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: two instances (settle 1 and 3) each driving a behavioural alu,
// checked against a transaction-level model of result, flags, latency and completion count.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [3:0]  req_sel    [2];
  logic [31:0] req_a      [2];
  logic [31:0] req_b      [2];
  logic [3:0]  alu_sel    [2];
  logic [31:0] alu_a      [2];
  logic [31:0] alu_b      [2];
  logic [31:0] alu_out    [2];
  logic        alu_z      [2];
  logic        alu_n      [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_result [2];
  logic        rsp_z      [2];
  logic        rsp_n      [2];
  logic        flag_z     [2];
  logic        flag_n     [2];
  logic        busy       [2];
  logic [15:0] op_count   [2];

  int          checks;
  int          failures;
  int          cyc;
  int          last_hs    [2];
  int          last_acc   [2];
  int          last_bp    [2];
  logic [15:0] exp_cnt    [2];
  logic        exp_fz     [2];
  logic        exp_fn     [2];

  // Reference alu: returns {z, n, result}.
  function automatic logic [33:0] alu_f(input logic [3:0] s, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (s)
      4'd0:    r = a + b;
      4'd1:    r = a & b;
      4'd2:    r = a | b;
      4'd3:    r = a - b;
      default: r = a ^ b;
    endcase
    return {(r == 32'd0), r[31], r};
  endfunction

  assign {alu_z[0], alu_n[0], alu_out[0]} = alu_f(alu_sel[0], alu_a[0], alu_b[0]);
  assign {alu_z[1], alu_n[1], alu_out[1]} = alu_f(alu_sel[1], alu_a[1], alu_b[1]);

  alu_issue_unit #(.WIDTH(32), .SEL_W(4), .SETTLE_CYCLES(1)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_select(req_sel[0]), .i_req_a(req_a[0]), .i_req_b(req_b[0]),
    .o_alu_select(alu_sel[0]), .o_alu_a(alu_a[0]), .o_alu_b(alu_b[0]),
    .i_alu_out(alu_out[0]), .i_alu_z(alu_z[0]), .i_alu_n(alu_n[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_result(rsp_result[0]), .o_rsp_z(rsp_z[0]), .o_rsp_n(rsp_n[0]),
    .o_flag_z(flag_z[0]), .o_flag_n(flag_n[0]), .o_busy(busy[0]), .o_op_count(op_count[0])
  );

  alu_issue_unit #(.WIDTH(32), .SEL_W(4), .SETTLE_CYCLES(3)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_select(req_sel[1]), .i_req_a(req_a[1]), .i_req_b(req_b[1]),
    .o_alu_select(alu_sel[1]), .o_alu_a(alu_a[1]), .o_alu_b(alu_b[1]),
    .i_alu_out(alu_out[1]), .i_alu_z(alu_z[1]), .i_alu_n(alu_n[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_result(rsp_result[1]), .o_rsp_z(rsp_z[1]), .o_rsp_n(rsp_n[1]),
    .o_flag_z(flag_z[1]), .o_flag_n(flag_n[1]), .o_busy(busy[1]), .o_op_count(op_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int d);
    check("rst_req_ready", req_ready[d], 1);
    check("rst_rsp_valid", rsp_valid[d], 0);
    check("rst_busy", busy[d], 0);
    check("rst_alu_sel", alu_sel[d], 0);
    check("rst_alu_a", alu_a[d], 0);
    check("rst_alu_b", alu_b[d], 0);
    check("rst_rsp_result", rsp_result[d], 0);
    check("rst_rsp_zn", {rsp_z[d], rsp_n[d]}, 0);
    check("rst_flags", {flag_z[d], flag_n[d]}, 0);
    check("rst_op_count", op_count[d], 0);
    exp_cnt[d] = 16'd0;
    exp_fz[d]  = 1'b0;
    exp_fn[d]  = 1'b0;
  endtask

  // One complete transaction on instance d, entered and left at a falling edge while idle.
  task automatic do_op(input int d, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input int bp, input bit b2b);
    logic [33:0] m;
    logic [15:0] nxt;
    int          acc;
    int          lat;
    int          s;
    s = (d == 0) ? 1 : 3;
    m = alu_f(sel, a, b);
    req_sel[d] = sel;
    req_a[d] = a;
    req_b[d] = b;
    req_valid[d] = 1'b1;
    rsp_ready[d] = (bp == 0);
    check("req_ready_idle", req_ready[d], 1);
    @(negedge clk);
    acc = cyc;
    if (b2b) begin
      check("accept_after_handshake", acc - last_hs[d], 1);
      if (last_bp[d] == 0) check("b2b_period", acc - last_acc[d], s + 2);
    end
    check("alu_sel_loaded", alu_sel[d], sel);
    check("alu_a_loaded", alu_a[d], a);
    check("alu_b_loaded", alu_b[d], b);
    check("busy_drive", busy[d], 1);
    check("req_ready_drive", req_ready[d], 0);
    if (bp > 0) begin
      req_sel[d] = 4'($urandom);
      req_a[d] = $urandom;
      req_b[d] = $urandom;
    end else begin
      req_valid[d] = 1'b0;
    end
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 20) begin
      check("alu_held_drive", {alu_sel[d], alu_a[d], alu_b[d]}, {sel, a, b});
      check("flags_before_capture", {flag_z[d], flag_n[d]}, {exp_fz[d], exp_fn[d]});
      @(negedge clk);
      lat++;
    end
    check("settle_latency", lat, s);
    nxt = exp_cnt[d] + 16'd1;
    exp_cnt[d] = nxt;
    exp_fz[d] = m[33];
    exp_fn[d] = m[32];
    check("rsp_result", rsp_result[d], m[31:0]);
    check("rsp_zn", {rsp_z[d], rsp_n[d]}, m[33:32]);
    check("flag_zn", {flag_z[d], flag_n[d]}, m[33:32]);
    check("op_count", op_count[d], nxt);
    repeat (bp) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid[d], 1);
      check("bp_rsp_stable", {rsp_z[d], rsp_n[d], rsp_result[d]}, m);
      check("bp_req_ready", req_ready[d], 0);
      check("bp_alu_held", {alu_sel[d], alu_a[d], alu_b[d]}, {sel, a, b});
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    last_hs[d] = cyc;
    check("rsp_valid_dropped", rsp_valid[d], 0);
    check("req_ready_after_hs", req_ready[d], 1);
    check("alu_kept_idle", {alu_sel[d], alu_a[d], alu_b[d]}, {sel, a, b});
    req_valid[d] = 1'b0;
    last_acc[d] = acc;
    last_bp[d] = bp;
  endtask

  // Start an op on instance d and reset mid-DRIVE (in_hold=0) or mid-HOLD (in_hold=1).
  task automatic do_abort(input int d, input bit in_hold);
    int n;
    req_sel[d] = 4'd0;
    req_a[d] = 32'd100;
    req_b[d] = 32'd23;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 0;
    if (in_hold) begin
      while (rsp_valid[d] !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("abort_reached_hold", rsp_valid[d], 1);
    end else begin
      check("abort_in_drive", {busy[d], rsp_valid[d]}, 2'b10);
    end
    rst_n = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid[d], 0);
      check("abort_not_counted", op_count[d], 0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
      req_sel[i] = 4'd0;
      req_a[i] = 32'd0;
      req_b[i] = 32'd0;
      last_hs[i] = 0;
      last_acc[i] = 0;
      last_bp[i] = 0;
    end
    #2;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, 4'd0, 32'd6, 32'd5, 0, 0);
    check("basic_result_const", rsp_result[0], 32'd11);
    check("basic_count_const", op_count[0], 16'd1);

    do_op(0, 4'd3, 32'd6, 32'd6, 0, 1);
    check("zero_flag_set", flag_z[0], 1'b1);
    do_op(0, 4'd3, 32'd6, 32'd5, 0, 1);
    check("zero_flag_clear", flag_z[0], 1'b0);
    do_op(0, 4'd3, 32'd5, 32'd6, 0, 1);
    check("neg_flag_set", flag_n[0], 1'b1);

    do_op(0, 4'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 5, 1);
    do_op(0, 4'd0, 32'd7, 32'd8, 0, 1);

    do_op(1, 4'd0, 32'd1, 32'd2, 0, 0);
    do_op(1, 4'd3, 32'd5, 32'd9, 0, 1);
    do_op(1, 4'd2, 32'h00FF_0000, 32'h0000_00FF, 0, 1);
    do_op(1, 4'd9, 32'hAAAA_5555, 32'hAAAA_5555, 2, 1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_op(i / 12, 4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2), (i % 12) != 0);
    end

    do_abort(1, 1'b0);
    do_abort(1, 1'b1);
    do_abort(0, 1'b1);
    do_op(1, 4'd0, 32'd40, 32'd2, 0, 0);

    force u_d0.r_op_count = 16'hFFFE;
    @(negedge clk);
    release u_d0.r_op_count;
    @(negedge clk);
    check("wrap_preload", op_count[0], 16'hFFFE);
    exp_cnt[0] = 16'hFFFE;
    do_op(0, 4'd0, 32'd3, 32'd4, 0, 0);
    check("wrap_ffff", op_count[0], 16'hFFFF);
    do_op(0, 4'd4, 32'd3, 32'd4, 0, 1);
    check("wrap_0000", op_count[0], 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front end for the combinational `alu` block. It accepts one operation request at a time (select, a, b) over a valid/ready handshake and drives the registered operands onto the ALU. After a fixed settle time it captures the ALU result and Z/N flags, then returns them over a valid/ready response channel with backpressure. It sits between the control/decode logic (the initiator) and the `alu`. It also holds the architectural condition flags and a completed-operation counter.

## Interface
- `WIDTH`, 32, operand/result width; must match `alu`.
- `SEL_W`, 4, ALU select width.
- `SETTLE_CYCLES`, 1, cycles the ALU inputs are held stable before capture; legal range 1–15.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_select`  in  SEL_W  ALU operation code.
- `req_a`, `req_b`  in  WIDTH  operands.
- `alu_select`  out  SEL_W  registered select to `alu`.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to `alu`.
- `alu_out`  in  WIDTH  `alu` result (combinational from `alu_*`).
- `alu_z`, `alu_n`  in  1  `alu` zero/negative flags.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_z`, `rsp_n`  out  1  captured flags for this response.
- `flag_z`, `flag_n`  out  1  flags from the last completed operation.
- `busy`  out  1  state is not IDLE.
- `op_count`  out  16  number of completed operations; wraps.

## Operation
- FSM states: IDLE, DRIVE, HOLD.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, register `req_select/a/b` into `alu_select/a/b`, load the settle counter with SETTLE_CYCLES-1, and go to DRIVE.
- DRIVE:
  - `req_ready`=0. `alu_*` are held constant.
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture `alu_out`→`rsp_result`, `alu_z`→`rsp_z`, and `alu_n`→`rsp_n`. On the same edge, copy the flags into `flag_z/flag_n`, increment `op_count`, and go to HOLD.
- HOLD:
  - `rsp_valid`=1. `rsp_*` are stable until the handshake completes.
  - On `rsp_ready`, go to IDLE.
  - `req_ready`=0 in HOLD, so a request offered in the same cycle is accepted only in the following IDLE cycle.
- `alu_*` keep their last values in IDLE and HOLD; they are not cleared after use.
- `req_select` is forwarded unmodified. Undefined codes are the `alu`'s concern and complete normally.
- `op_count` wraps 16'hFFFF→16'h0000 without any flag.
- Flags update only on capture. A response discarded by reset does not update them.

## Timing
- Reset (`rst_n`=0, asynchronous, any state):
  - State goes to IDLE, the counter to 0, and `op_count` to 0.
  - `alu_select`, `alu_a`, `alu_b`, `rsp_result`, `rsp_z`, `rsp_n`, `flag_z`, `flag_n` all go to 0.
  - `rsp_valid`=0, `busy`=0.
  - `req_ready` reads 1 because it decodes IDLE, but no accept occurs while `rst_n` is low.
- Reset mid-DRIVE or mid-HOLD aborts the operation. No response is produced and the operation is not counted.
- Request accepted at edge k:
  - `alu_*` are valid after edge k.
  - Capture happens at edge k+SETTLE_CYCLES, and `rsp_valid` rises after that edge.
- With `rsp_ready` held high, `rsp_valid` lasts 1 cycle. The next accept can occur at edge k+SETTLE_CYCLES+2. Peak throughput is one operation per SETTLE_CYCLES+2 cycles.
- `req_ready`, `rsp_valid` and `busy` are decoded from state only; there is no combinational path from `req_valid` or `rsp_ready`.
- The `alu` combinational delay must fit within SETTLE_CYCLES clock periods.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-DRIVE and mid-HOLD → all outputs at their reset values, `req_ready`=1 once released, `op_count`=0, no `rsp_valid` pulse.
- **Basic operation:** with the `alu` instantiated, SETTLE_CYCLES=1, send select=0000, a=6, b=5, and hold `rsp_ready`=1 → `rsp_valid` is asserted exactly 1 cycle after the accept edge. `rsp_result`/Z/N equal `alu` outputs for (0000, 6, 5), `op_count`=1.
- **Zero flag:** send select=0011, a=6, b=6 → `rsp_z`, `rsp_n` and `flag_z`/`flag_n` equal the `alu`'s Z/N for (0011, 6, 6), with Z=1 expected. A following request select=0011, a=6, b=5 → `flag_z` matches the new `alu` Z (0 expected) and is updated only at capture.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles while `req_valid`=1 with new operands → `rsp_*` stable, `req_ready`=0, `alu_*` unchanged. Release `rsp_ready` → the next request is accepted one cycle after the handshake.
- **Settle time:** with SETTLE_CYCLES=3 → `rsp_valid` rises 3 cycles after accept, `alu_*` are constant during DRIVE, and back-to-back requests complete every 5 cycles.
- **Counter wrap:** preload `op_count` to 16'hFFFE via 65534 operations (or a forced value), then complete 2 operations → 16'hFFFF, then 16'h0000.
